// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
//   - Register offsets inside the 16-byte window (word aligned, byte lanes ignored)
//   - STATUS bit positions
//   - TX state machine encoding
//   - bit_period(): turns a DIVISOR value into a usable bit period
package uart_tx_mmio_pkg;

    localparam logic [3:0] REG_TXDATA  = 4'h0;
    localparam logic [3:0] REG_STATUS  = 4'h4;
    localparam logic [3:0] REG_DIVISOR = 4'h8;

    localparam int STATUS_FULL_BIT  = 0;
    localparam int STATUS_EMPTY_BIT = 1;
    localparam int STATUS_BUSY_BIT  = 2;
    localparam int STATUS_OVF_BIT   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    // A divisor of zero would give a zero-length bit; run it as one cycle per bit.
    function automatic logic [15:0] bit_period(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//   clk, reset       clock and synchronous active-high reset (pointers only)
//   push, push_data  write strobe and data; ignored while full
//   pop              read strobe; ignored while empty
//   pop_data         head entry, valid whenever empty is low
//   full, empty      occupancy flags derived from the pointers
// DEPTH must be a power of two and at least 2. Pointers carry one extra
// wrap bit so that full and empty are distinguishable when the address
// bits match.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage has no reset: contents are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter on the core data port.
//   clk, reset     system clock, synchronous active-high reset
//   mem_addr       load/store address; window hit on [31:4], register on [3:2]
//   mem_r_enable   one-cycle load strobe
//   mem_w_enable   one-cycle store strobe
//   mem_wdata      store data (unshifted rs2)
//   mmio_rdata     registered read data, held until the next load
//   mmio_hit_q     high while mmio_rdata belongs to a load that hit the window
//   tx             serial output, idle high
//   busy           transmitter not in IDLE
// Registers: 0x0 TXDATA (W push byte), 0x4 STATUS (R full/empty/busy/overflow,
// W bit3 clears overflow), 0x8 DIVISOR (R/W 16 bits), 0xC reads as zero.
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [15:0] CLKS_PER_BIT = 16'd868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic        mem_r_enable,
    input  logic        mem_w_enable,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mmio_rdata,
    output logic        mmio_hit_q,
    output logic        tx,
    output logic        busy
);

    // ---------------- address decode ----------------
    logic       reg_hit;
    logic [3:0] reg_off;
    logic       wr_txdata, wr_status, wr_divisor;

    assign reg_hit    = (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign reg_off    = {mem_addr[3:2], 2'b00};
    assign wr_txdata  = mem_w_enable && reg_hit && (reg_off == REG_TXDATA);
    assign wr_status  = mem_w_enable && reg_hit && (reg_off == REG_STATUS);
    assign wr_divisor = mem_w_enable && reg_hit && (reg_off == REG_DIVISOR);

    // Byte lanes and upper store bits play no part in any register.
    logic unused_bits;
    assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:16]};

    // ---------------- TX FIFO ----------------
    logic       fifo_pop;
    logic [7:0] fifo_data;
    logic       fifo_full, fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_txdata),
        .push_data (mem_wdata[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // ---------------- register file ----------------
    logic [15:0] divisor_q, divisor_d;
    logic        overflow_q, overflow_d;
    logic [31:0] rdata_q, rdata_d;
    logic        hit_q, hit_d;
    logic [31:0] status_word, read_word;

    always_comb begin
        divisor_d = divisor_q;
        if (wr_divisor) divisor_d = mem_wdata[15:0];

        // Full is the pre-edge flag, so a same-edge pop does not save the
        // byte; a set also beats a simultaneous clear.
        overflow_d = overflow_q;
        if (wr_status && mem_wdata[STATUS_OVF_BIT]) overflow_d = 1'b0;
        if (wr_txdata && fifo_full)                  overflow_d = 1'b1;
    end

    always_comb begin
        status_word                   = '0;
        status_word[STATUS_FULL_BIT]  = fifo_full;
        status_word[STATUS_EMPTY_BIT] = fifo_empty;
        status_word[STATUS_BUSY_BIT]  = busy;
        status_word[STATUS_OVF_BIT]   = overflow_q;

        case (reg_off)
            REG_STATUS:  read_word = status_word;
            REG_DIVISOR: read_word = {16'd0, divisor_q};
            default:     read_word = '0;
        endcase

        // A load that misses drops the hit flag but leaves the data alone.
        rdata_d = rdata_q;
        hit_d   = hit_q;
        if (mem_r_enable) begin
            hit_d = reg_hit;
            if (reg_hit) rdata_d = read_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            divisor_q  <= CLKS_PER_BIT;
            overflow_q <= 1'b0;
            rdata_q    <= '0;
            hit_q      <= 1'b0;
        end else begin
            divisor_q  <= divisor_d;
            overflow_q <= overflow_d;
            rdata_q    <= rdata_d;
            hit_q      <= hit_d;
        end
    end

    assign mmio_rdata = rdata_q;
    assign mmio_hit_q = hit_q;

    // ---------------- TX state machine ----------------
    uart_tx_state_t state_q, state_d;
    logic [15:0]    bit_cnt_q, bit_cnt_d;
    logic [15:0]    period_q, period_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [7:0]     shift_q, shift_d;
    logic           bit_done;

    assign bit_done = (bit_cnt_q == period_q - 16'd1);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            period_q  <= 16'd1;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            period_q  <= period_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    // Next-state logic. The period is latched once per frame, so DIVISOR
    // writes during a frame only take effect on the following one.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        period_d  = period_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d   = START;
                    shift_d   = fifo_data;
                    period_d  = bit_period(divisor_q);
                    bit_cnt_d = '0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    bit_cnt_d = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    bit_cnt_d = '0;
                    // Chain straight into the next start bit when data waits.
                    if (!fifo_empty) begin
                        state_d  = START;
                        shift_d  = fifo_data;
                        period_d = bit_period(divisor_q);
                    end else begin
                        state_d  = IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        fifo_pop = 1'b0;
        tx       = 1'b1;
        busy     = (state_q != IDLE);
        case (state_q)
            IDLE:    fifo_pop = !fifo_empty;
            START:   tx = 1'b0;
            DATA:    tx = shift_q[0];
            STOP:    fifo_pop = bit_done && !fifo_empty;
            default: tx = 1'b1;
        endcase
    end

endmodule
